// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: byte-protocol host bridge to core control/status registers, with TX FIFO.
// Define UART_REG_BRIDGE_WR_ACK_EN to return an acknowledge byte after every write frame.
module uart_reg_bridge #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned NUM_WR      = 2,
  parameter int unsigned NUM_RD      = 2,
  parameter int unsigned TXF_DEPTH   = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     rx_error,
  input  logic                     tx_ready,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  output logic [NUM_WR*DATA_W-1:0] wr_regs,
  output logic [NUM_WR-1:0]        wr_strobe,
  input  logic [NUM_RD*DATA_W-1:0] rd_regs,
  input  logic [1:0]               core_flags,
  output logic                     alg_rst,
  output logic                     alg_en,
  output logic                     src_sel,
  output logic                     irq
);
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(BYTES + 1);
  localparam int unsigned PTR_W = $clog2(TXF_DEPTH);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_WR_DATA, S_RD_LOAD, S_RD_PUSH, S_WR_ACK} state_e;

  state_e                   state_q, state_d;
  logic [6:0]               addr_q, addr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]        asm_q, asm_d;
  logic [DATA_W-1:0]        snap_q, snap_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [7:0]               cr_q, cr_d;
  logic [3:0]               sr_err_q, sr_err_d;
  logic [NUM_WR*DATA_W-1:0] wr_regs_q, wr_regs_d;
  logic [NUM_WR-1:0]        wr_strobe_q, wr_strobe_d;
  logic                     irq_q, irq_d;
  logic [7:0]               fifo_q [TXF_DEPTH];
  logic [7:0]               fifo_d [TXF_DEPTH];
  logic [PTR_W-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]           fcnt_q, fcnt_d;
`ifdef UART_REG_BRIDGE_WR_ACK_EN
  logic [7:0]               ack_q, ack_d;
`endif

  logic              txf_empty_c, txf_full_c, pop_c, can_push_c, push_c, rx_byte_c;
  logic              rd_hit_c, wr_hit_c;
  logic [7:0]        push_byte_c, sr_c;
  logic [3:0]        sr_set_c, sr_clr_c;
  logic [DATA_W-1:0] word_c, rd_val_c;

  assign txf_empty_c = (fcnt_q == '0);
  assign txf_full_c  = (fcnt_q == (PTR_W+1)'(TXF_DEPTH));
  assign pop_c       = !txf_empty_c && tx_ready;
  assign can_push_c  = !txf_full_c || pop_c;
  assign rx_byte_c   = rx_valid && !rx_error;
  assign sr_c        = {core_flags, txf_full_c, txf_empty_c, sr_err_q};
  // Bytes arrive LSB first: shift each new byte in from the top.
  assign word_c      = (asm_q >> 8) | (DATA_W'(rx_data) << (DATA_W - 8));

  // Read-side address decode.
  always_comb begin
    rd_val_c = '0;
    rd_hit_c = 1'b0;
    if (addr_q == 7'h00) begin
      rd_val_c = DATA_W'(cr_q);
      rd_hit_c = 1'b1;
    end else if (addr_q == 7'h01) begin
      rd_val_c = DATA_W'(sr_c);
      rd_hit_c = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      if (addr_q == 7'(16 + i)) begin
        rd_val_c = wr_regs_q[i*DATA_W +: DATA_W];
        rd_hit_c = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (addr_q == 7'(32 + i)) begin
        rd_val_c = rd_regs[i*DATA_W +: DATA_W];
        rd_hit_c = 1'b1;
      end
    end
  end

  // Frame FSM, register file updates and FIFO bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    snap_d      = snap_q;
    tmo_d       = tmo_q;
    cr_d        = cr_q;
    wr_regs_d   = wr_regs_q;
    wr_strobe_d = '0;
    push_c      = 1'b0;
    push_byte_c = snap_q[7:0];
    sr_set_c    = '0;
    sr_clr_c    = '0;
    wr_hit_c    = 1'b0;
`ifdef UART_REG_BRIDGE_WR_ACK_EN
    ack_d       = ack_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tmo_d = '0;
        if (rx_byte_c) begin
          addr_d  = rx_data[6:0];
          asm_d   = '0;
          state_d = rx_data[7] ? S_WR_DATA : S_RD_LOAD;
        end
      end
      S_WR_DATA: begin
        if (rx_error) begin
          state_d = S_IDLE;
        end else if (rx_valid) begin
          asm_d = word_c;
          tmo_d = '0;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BYTES - 1)) begin
            if (addr_q == 7'h00) begin
              cr_d     = word_c[7:0];
              wr_hit_c = 1'b1;
            end else if (addr_q == 7'h01) begin
              sr_clr_c = word_c[3:0];
              wr_hit_c = 1'b1;
            end
            for (int unsigned i = 0; i < NUM_WR; i++) begin
              if (addr_q == 7'(16 + i)) begin
                wr_regs_d[i*DATA_W +: DATA_W] = word_c;
                wr_strobe_d[i]                = 1'b1;
                wr_hit_c                      = 1'b1;
              end
            end
            sr_set_c[1] = !wr_hit_c;
`ifdef UART_REG_BRIDGE_WR_ACK_EN
            ack_d   = wr_hit_c ? 8'hA5 : 8'hEE;
            state_d = S_WR_ACK;
`else
            state_d = S_IDLE;
`endif
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          sr_set_c[2] = 1'b1;
`ifdef UART_REG_BRIDGE_WR_ACK_EN
          ack_d   = 8'hEE;
          state_d = S_WR_ACK;
`else
          state_d = S_IDLE;
`endif
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RD_LOAD: begin
        if (rx_error) begin
          state_d = S_IDLE;
        end else begin
          sr_set_c[3] = rx_valid;
          sr_set_c[1] = !rd_hit_c;
          snap_d      = rd_val_c;
          cnt_d       = '0;
          state_d     = S_RD_PUSH;
        end
      end
      S_RD_PUSH: begin
        sr_set_c[3] = rx_byte_c;
        if (can_push_c) begin
          push_c = 1'b1;
          snap_d = snap_q >> 8;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BYTES - 1)) state_d = S_IDLE;
        end
      end
`ifdef UART_REG_BRIDGE_WR_ACK_EN
      S_WR_ACK: begin
        sr_set_c[3] = rx_byte_c;
        push_byte_c = ack_q;
        if (can_push_c) begin
          push_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (rx_error) sr_set_c[0] = 1'b1;
    // A new error event in the same cycle as a clear write keeps its bit set.
    sr_err_d = (sr_err_q & ~sr_clr_c) | sr_set_c;
    irq_d    = |(sr_err_d & cr_d[7:4]);

    fifo_d = fifo_q;
    if (push_c) fifo_d[wptr_q] = push_byte_c;
    wptr_d = push_c ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d = pop_c  ? rptr_q + PTR_W'(1) : rptr_q;
    fcnt_d = fcnt_q;
    if (push_c && !pop_c)      fcnt_d = fcnt_q + (PTR_W+1)'(1);
    else if (!push_c && pop_c) fcnt_d = fcnt_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      asm_q       <= '0;
      snap_q      <= '0;
      tmo_q       <= '0;
      cr_q        <= '0;
      sr_err_q    <= '0;
      wr_regs_q   <= '0;
      wr_strobe_q <= '0;
      irq_q       <= 1'b0;
      fifo_q      <= '{default: '0};
      wptr_q      <= '0;
      rptr_q      <= '0;
      fcnt_q      <= '0;
`ifdef UART_REG_BRIDGE_WR_ACK_EN
      ack_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      snap_q      <= snap_d;
      tmo_q       <= tmo_d;
      cr_q        <= cr_d;
      sr_err_q    <= sr_err_d;
      wr_regs_q   <= wr_regs_d;
      wr_strobe_q <= wr_strobe_d;
      irq_q       <= irq_d;
      fifo_q      <= fifo_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fcnt_q      <= fcnt_d;
`ifdef UART_REG_BRIDGE_WR_ACK_EN
      ack_q       <= ack_d;
`endif
    end
  end

  assign tx_valid  = !txf_empty_c;
  assign tx_data   = fifo_q[rptr_q];
  assign wr_regs   = wr_regs_q;
  assign wr_strobe = wr_strobe_q;
  assign alg_rst   = cr_q[0];
  assign alg_en    = cr_q[1];
  assign src_sel   = cr_q[2];
  assign irq       = irq_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge: expected TX bytes are queued as host frames are sent.
module tb_uart_reg_bridge;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned NUM_WR      = 2;
  localparam int unsigned NUM_RD      = 2;
  localparam int unsigned TXF_DEPTH   = 8;
  localparam int unsigned TIMEOUT_CYC = 64;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     rx_valid = 1'b0;
  logic [7:0]               rx_data = '0;
  logic                     rx_error = 1'b0;
  logic                     tx_ready = 1'b1;
  logic                     tx_valid;
  logic [7:0]               tx_data;
  logic [NUM_WR*DATA_W-1:0] wr_regs;
  logic [NUM_WR-1:0]        wr_strobe;
  logic [NUM_RD*DATA_W-1:0] rd_regs = '0;
  logic [1:0]               core_flags = 2'b10;
  logic                     alg_rst, alg_en, src_sel, irq;

  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int n_tx = 0;
  int strobe_cnt [NUM_WR];
  int tx_mark;

  uart_reg_bridge #(
    .DATA_W(DATA_W), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD),
    .TXF_DEPTH(TXF_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .wr_regs(wr_regs),
    .wr_strobe(wr_strobe), .rd_regs(rd_regs), .core_flags(core_flags),
    .alg_rst(alg_rst), .alg_en(alg_en), .src_sel(src_sel), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) begin
        n_tx++;
        if (exp_q.size() == 0) check("tx_unexpected", 32'(exp_q.size()), 32'd1);
        else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      for (int i = 0; i < NUM_WR; i++) if (wr_strobe[i]) strobe_cnt[i]++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic reg_write(input logic [6:0] addr, input logic [15:0] data, input bit ok);
`ifdef UART_REG_BRIDGE_WR_ACK_EN
    exp_q.push_back(ok ? 8'hA5 : 8'hEE);
`endif
    send_byte({1'b1, addr});
    send_byte(data[7:0]);
    send_byte(data[15:8]);
    if (ok) begin end
  endtask

  task automatic reg_read(input logic [6:0] addr, input logic [15:0] exp);
    exp_q.push_back(exp[7:0]);
    exp_q.push_back(exp[15:8]);
    send_byte({1'b0, addr});
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NUM_WR; i++) strobe_cnt[i] = 0;
    rd_regs = {16'h5A3C, 16'hBEEF};
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_wr_regs", wr_regs, 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_cr", 32'({alg_rst, alg_en, src_sel}), 32'd0);

    // Basic write then status read.
    reg_write(7'h10, 16'h1234, 1'b1);
    check("wr0_value", 32'(wr_regs[15:0]), 32'h1234);
    check("wr0_strobe", 32'(strobe_cnt[0]), 32'd1);
    wait_drain();
    reg_read(7'h01, 16'h0090);
    wait_drain();

    // Coherent snapshot: core value changes right after the load cycle.
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE);
    send_byte(8'h20);
    rd_regs[15:0] = 16'h0000;
    repeat (4) @(posedge clk);
    #1;
    wait_drain();

    reg_write(7'h00, 16'h0007, 1'b1);
    check("cr_bits", 32'({src_sel, alg_en, alg_rst}), 32'h7);
    wait_drain();

    // Back-pressure: 4 reads fill the FIFO, the SR read snapshots full and then stalls.
    tx_ready = 1'b0;
    tx_mark = n_tx;
    reg_read(7'h10, 16'h1234);
    reg_read(7'h11, 16'h0000);
    reg_read(7'h21, 16'h5A3C);
    reg_read(7'h00, 16'h0007);
    reg_read(7'h01, 16'h00A0);
    repeat (20) @(posedge clk);
    #1;
    check("stall_no_tx", 32'(n_tx - tx_mark), 32'd0);
    check("stall_tx_valid", 32'(tx_valid), 32'd1);
    tx_ready = 1'b1;
    wait_drain();
    check("stall_tx_count", 32'(n_tx - tx_mark), 32'd10);

    // Inter-byte timeout discards the partial write.
`ifdef UART_REG_BRIDGE_WR_ACK_EN
    exp_q.push_back(8'hEE);
`endif
    send_byte(8'h90);
    send_byte(8'h56);
    repeat (TIMEOUT_CYC + 8) @(posedge clk);
    #1;
    check("tmo_wr0", 32'(wr_regs[15:0]), 32'h1234);
    check("tmo_strobe", 32'(strobe_cnt[0]), 32'd1);
    reg_write(7'h00, 16'h0040, 1'b1);
    check("tmo_irq_set", 32'(irq), 32'd1);
    check("cr_cleared", 32'({src_sel, alg_en, alg_rst}), 32'h0);
    wait_drain();
    reg_read(7'h01, 16'h0094);
    wait_drain();
    reg_write(7'h01, 16'h0004, 1'b1);
    check("tmo_irq_clr", 32'(irq), 32'd0);
    wait_drain();

    // Invalid and read-only write targets.
    reg_write(7'h7F, 16'h0000, 1'b0);
    reg_write(7'h20, 16'hFFFF, 1'b0);
    check("adr_strobe0", 32'(strobe_cnt[0]), 32'd1);
    check("adr_strobe1", 32'(strobe_cnt[1]), 32'd0);
    wait_drain();
    reg_read(7'h01, 16'h0092);
    wait_drain();

    // Framing error mid-write, then a clean frame.
    send_byte(8'h91);
    send_byte(8'hCD);
    rx_data = 8'hEF;
    rx_valid = 1'b1;
    rx_error = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_error = 1'b0;
    @(posedge clk); #1;
    check("rxerr_no_strobe", 32'(strobe_cnt[1]), 32'd0);
    reg_write(7'h11, 16'hBEAD, 1'b1);
    check("rxerr_wr1", 32'(wr_regs[31:16]), 32'hBEAD);
    check("rxerr_strobe1", 32'(strobe_cnt[1]), 32'd1);
    wait_drain();
    reg_read(7'h01, 16'h0093);
    wait_drain();

    // Byte arriving during the load cycle is dropped and flags overrun.
    rd_regs[15:0] = 16'h1357;
    exp_q.push_back(8'h57);
    exp_q.push_back(8'h13);
    rx_data = 8'h20;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_data = 8'h99;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    wait_drain();
    reg_read(7'h01, 16'h009B);
    wait_drain();

    reg_write(7'h01, 16'h000F, 1'b1);
    core_flags = 2'b01;
    wait_drain();
    reg_read(7'h01, 16'h0050);
    wait_drain();
    check("final_irq", 32'(irq), 32'd0);
    check("final_wr0", 32'(wr_regs[15:0]), 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
